multi_edge_detect: RTL

//  Multi-channel synchroniser, debouncer and edge detector for asynchronous inputs (paddle buttons, serve/reset keys).
//  Per channel: parametrised sync chain, optional debounce filter, and a one-cycle edge pulse selectable as rise/fall/both/off.

---
 rtl/edge_pkg.sv | 31 +++
 rtl/edge_chan.sv | 75 +++++++
 rtl/multi_edge_detect.sv | 44 ++++
 3 files changed

// File: rtl/edge_pkg.sv
// Shared types and helpers for the multi-channel synchroniser / debouncer / edge detector.
package edge_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_OFF  = 2'b11
    } edge_mode_e;

    localparam int SYNC_MIN = 2;

    // A debounce length of 0 behaves exactly like 1 (change accepted on first differing cycle).
    function automatic int db_eff(input int db);
        return (db < 1) ? 1 : db;
    endfunction

    function automatic logic edge_qualify(input edge_mode_e mode, input logic prev, input logic cur);
        logic w_hit;
        w_hit = 1'b0;
        case (mode)
            EDGE_RISE: w_hit = ~prev & cur;
            EDGE_FALL: w_hit = prev & ~cur;
            EDGE_BOTH: w_hit = prev ^ cur;
            EDGE_OFF:  w_hit = 1'b0;
            default:   w_hit = 1'b0;
        endcase
        return w_hit;
    endfunction

endpackage

// File: rtl/edge_chan.sv
// One input channel: sync chain, debounce counter, registered edge qualifier and sticky event flag.
module edge_chan
    import edge_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   DB_CYCLES   = 0,
    parameter logic IDLE_LEVEL  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sig_in,
    input  edge_mode_e mode,
    input  logic       evt_clr,
    output logic       sig_clean,
    output logic       sig_edge,
    output logic       evt_flag
);

    localparam int                DB_EFF   = db_eff(DB_CYCLES);
    localparam int                CNT_W    = $clog2(DB_EFF + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_EFF - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_clean;
    logic                   r_clean_d;
    logic                   r_edge;
    logic                   r_flag;
    logic                   w_sync_q;
    logic                   w_edge_next;

    assign w_sync_q = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{IDLE_LEVEL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
        end
    end

    // Any return to the clean level restarts the count; the counter stops at CNT_LAST so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clean <= IDLE_LEVEL;
            r_cnt   <= '0;
        end else if (w_sync_q == r_clean) begin
            r_cnt   <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_clean <= w_sync_q;
            r_cnt   <= '0;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    assign w_edge_next = edge_qualify(mode, r_clean_d, r_clean);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clean_d <= IDLE_LEVEL;
            r_edge    <= 1'b0;
            r_flag    <= 1'b0;
        end else begin
            r_clean_d <= r_clean;
            r_edge    <= w_edge_next;
            r_flag    <= (r_flag & ~evt_clr) | w_edge_next;
        end
    end

    assign sig_clean = r_clean;
    assign sig_edge  = r_edge;
    assign evt_flag  = r_flag;

endmodule

// File: rtl/multi_edge_detect.sv
// Multi-channel input conditioner: replicates edge_chan per channel with a shared edge mode.
module multi_edge_detect
    import edge_pkg::*;
#(
    parameter int   CH          = 4,
    parameter int   SYNC_STAGES = 2,
    parameter int   DB_CYCLES   = 0,
    parameter logic IDLE_LEVEL  = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] sig_in,
    input  edge_mode_e    mode,
    input  logic [CH-1:0] evt_clr,
    output logic [CH-1:0] sig_clean,
    output logic [CH-1:0] sig_edge,
    output logic [CH-1:0] evt_flag
);

    if (SYNC_STAGES < SYNC_MIN) begin : g_bad_sync
        $error("multi_edge_detect: SYNC_STAGES must be >= %0d", SYNC_MIN);
    end
    if (CH < 1) begin : g_bad_ch
        $error("multi_edge_detect: CH must be >= 1");
    end

    for (genvar i = 0; i < CH; i++) begin : g_chan
        edge_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES),
            .IDLE_LEVEL  (IDLE_LEVEL)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .sig_in    (sig_in[i]),
            .mode      (mode),
            .evt_clr   (evt_clr[i]),
            .sig_clean (sig_clean[i]),
            .sig_edge  (sig_edge[i]),
            .evt_flag  (evt_flag[i])
        );
    end

endmodule
